// File: rtl/axis_arb_pkg.sv
// ============================================================================
// Module : axis_arb_pkg
// Brief  : Shared types and width helpers for the AXI-Stream frame arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package axis_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Accumulating INP_DEPTH beats needs clog2(depth) guard bits over the beat width.
  function automatic int out_width(input int iw, input int depth);
    return iw + clog2(depth);
  endfunction

  localparam int c_DEF_IW        = 32;
  localparam int c_DEF_INP_DEPTH = 8;
  localparam int c_DEF_OW        = out_width(c_DEF_IW, c_DEF_INP_DEPTH);

endpackage

`default_nettype wire

// File: rtl/axis_frame_arbiter_rr_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin selector (rotate, priority-encode, un-rotate).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_pick
  import axis_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic [ID_WIDTH-1:0] last_i,
  output logic                any_o,
  output logic [ID_WIDTH-1:0] idx_o
);

  logic [NUM_REQ-1:0] w_rot;
  int                 w_start;
  int                 w_off;
  logic               w_found;

  // Rotation puts last+1 at position 0 so the lowest set bit is the winner.
  always_comb begin
    w_start = (int'(last_i) + 1) % NUM_REQ;
    w_rot   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_rot[i] = req_i[(w_start + i) % NUM_REQ];
    end
  end

  always_comb begin
    w_off   = 0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_rot[i] && !w_found) begin
        w_found = 1'b1;
        w_off   = i;
      end
    end
    any_o = |req_i;
    idx_o = ID_WIDTH'((w_start + w_off) % NUM_REQ);
  end

endmodule

`default_nettype wire

// File: rtl/axis_frame_arbiter.sv
// ============================================================================
// Module : axis_frame_arbiter
// Brief  : Grants one shared AXI-Stream frame engine to NUM_REQ requesters,
//          one whole frame at a time, in round-robin order.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module axis_frame_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_REQ           = 4,
  parameter int INP_DEPTH         = 8,
  parameter int OUT_DEPTH         = 2,
  parameter int INPUT_DATA_WIDTH  = 32,
  parameter int OUTPUT_DATA_WIDTH = out_width(INPUT_DATA_WIDTH, INP_DEPTH),
  parameter int ID_WIDTH          = clog2(NUM_REQ)
) (
  input  logic                                axi_clk,
  input  logic                                axi_reset,
  input  logic [NUM_REQ-1:0]                  s_axis_valid,
  input  logic [NUM_REQ*INPUT_DATA_WIDTH-1:0] s_axis_data,
  output logic [NUM_REQ-1:0]                  s_axis_ready,
  output logic                                e_axis_valid,
  output logic [INPUT_DATA_WIDTH-1:0]         e_axis_data,
  input  logic                                e_axis_ready,
  input  logic                                r_axis_valid,
  input  logic [OUTPUT_DATA_WIDTH-1:0]        r_axis_data,
  output logic                                r_axis_ready,
  output logic [NUM_REQ-1:0]                  m_axis_valid,
  output logic [OUTPUT_DATA_WIDTH-1:0]        m_axis_data,
  output logic [ID_WIDTH-1:0]                 m_axis_id,
  input  logic [NUM_REQ-1:0]                  m_axis_ready,
  output logic                                busy,
  output logic [ID_WIDTH-1:0]                 grant_id
);

  localparam int c_beat_w = (clog2(INP_DEPTH) > 0) ? clog2(INP_DEPTH) : 1;
  localparam int c_out_w  = (clog2(OUT_DEPTH) > 0) ? clog2(OUT_DEPTH) : 1;
  localparam logic [c_beat_w-1:0] c_BEAT_LAST = c_beat_w'(INP_DEPTH - 1);
  localparam logic [c_out_w-1:0]  c_OUT_LAST  = c_out_w'(OUT_DEPTH - 1);
  localparam logic [ID_WIDTH-1:0] c_LAST_RST  = ID_WIDTH'(NUM_REQ - 1);

  arb_state_e            state_q, state_d;
  logic [ID_WIDTH-1:0]   grant_q, grant_d;
  logic [ID_WIDTH-1:0]   last_q, last_d;
  logic [c_beat_w-1:0]   beat_q, beat_d;
  logic [c_out_w-1:0]    out_q, out_d;

  logic                  w_any;
  logic [ID_WIDTH-1:0]   w_pick;
  logic                  w_e_hs;
  logic                  w_r_hs;

  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_pick (
    .req_i  (s_axis_valid),
    .last_i (last_q),
    .any_o  (w_any),
    .idx_o  (w_pick)
  );

  assign w_e_hs = (state_q == ST_FEED)  && s_axis_valid[grant_q] && e_axis_ready;
  assign w_r_hs = (state_q == ST_DRAIN) && r_axis_valid && m_axis_ready[grant_q];

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= c_LAST_RST;
      beat_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    beat_d  = beat_q;
    out_d   = out_q;
    case (state_q)
      ST_IDLE: begin
        if (w_any) begin
          grant_d = w_pick;
          state_d = ST_FEED;
        end
      end
      ST_FEED: begin
        if (w_e_hs) begin
          if (beat_q == c_BEAT_LAST) begin
            beat_d  = '0;
            state_d = ST_DRAIN;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        // last_grant only moves once the owner has taken its final result.
        if (w_r_hs) begin
          if (out_q == c_OUT_LAST) begin
            out_d   = '0;
            last_d  = grant_q;
            state_d = ST_IDLE;
          end else begin
            out_d = out_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_axis_ready = '0;
    e_axis_valid = 1'b0;
    e_axis_data  = '0;
    r_axis_ready = 1'b0;
    m_axis_valid = '0;
    m_axis_data  = '0;
    m_axis_id    = '0;
    busy         = (state_q != ST_IDLE);
    case (state_q)
      ST_FEED: begin
        e_axis_valid          = s_axis_valid[grant_q];
        e_axis_data           = s_axis_data[int'(grant_q)*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH];
        s_axis_ready[grant_q] = e_axis_ready;
      end
      ST_DRAIN: begin
        m_axis_valid[grant_q] = r_axis_valid;
        r_axis_ready          = m_axis_ready[grant_q];
        m_axis_data           = r_axis_data;
        m_axis_id             = grant_q;
      end
      default: ;
    endcase
  end

  assign grant_id = grant_q;

endmodule

`default_nettype wire

// File: tb/tb_axis_frame_arbiter.sv
// ============================================================================
// Module : tb_axis_frame_arbiter
// Brief  : Self-checking bench with a frame-level requester/engine model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_axis_frame_arbiter;

  localparam int NR  = 4;
  localparam int INP = 8;
  localparam int OD  = 2;
  localparam int IW  = 32;
  localparam int OW  = 35;
  localparam int IDW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [NR-1:0]    s_valid;
  logic [NR*IW-1:0] s_data;
  logic [NR-1:0]    s_ready;
  logic             e_valid;
  logic [IW-1:0]    e_data;
  logic             e_ready;
  logic             r_valid;
  logic [OW-1:0]    r_data;
  logic             r_ready;
  logic [NR-1:0]    m_valid;
  logic [OW-1:0]    m_data;
  logic [IDW-1:0]   m_id;
  logic [NR-1:0]    m_ready;
  logic             busy;
  logic [IDW-1:0]   grant_id;

  axis_frame_arbiter #(
    .NUM_REQ(NR), .INP_DEPTH(INP), .OUT_DEPTH(OD),
    .INPUT_DATA_WIDTH(IW), .OUTPUT_DATA_WIDTH(OW), .ID_WIDTH(IDW)
  ) dut (
    .axi_clk(clk), .axi_reset(rst),
    .s_axis_valid(s_valid), .s_axis_data(s_data), .s_axis_ready(s_ready),
    .e_axis_valid(e_valid), .e_axis_data(e_data), .e_axis_ready(e_ready),
    .r_axis_valid(r_valid), .r_axis_data(r_data), .r_axis_ready(r_ready),
    .m_axis_valid(m_valid), .m_axis_data(m_data), .m_axis_id(m_id),
    .m_axis_ready(m_ready), .busy(busy), .grant_id(grant_id)
  );

  // Degenerate instance: two requesters, one beat in, one result out.
  logic [1:0]    s2_valid;
  logic [63:0]   s2_data;
  logic [1:0]    s2_ready;
  logic          e2_valid;
  logic [31:0]   e2_data;
  logic          e2_ready;
  logic          r2_valid;
  logic [31:0]   r2_data;
  logic          r2_ready;
  logic [1:0]    m2_valid;
  logic [31:0]   m2_data;
  logic [0:0]    m2_id;
  logic [1:0]    m2_ready;
  logic          busy2;
  logic [0:0]    grant2;

  axis_frame_arbiter #(
    .NUM_REQ(2), .INP_DEPTH(1), .OUT_DEPTH(1),
    .INPUT_DATA_WIDTH(32), .OUTPUT_DATA_WIDTH(32), .ID_WIDTH(1)
  ) dut2 (
    .axi_clk(clk), .axi_reset(rst),
    .s_axis_valid(s2_valid), .s_axis_data(s2_data), .s_axis_ready(s2_ready),
    .e_axis_valid(e2_valid), .e_axis_data(e2_data), .e_axis_ready(e2_ready),
    .r_axis_valid(r2_valid), .r_axis_data(r2_data), .r_axis_ready(r2_ready),
    .m_axis_valid(m2_valid), .m_axis_data(m2_data), .m_axis_id(m2_id),
    .m_axis_ready(m2_ready), .busy(busy2), .grant_id(grant2)
  );

  int errors = 0;
  int checks = 0;

  // Frame-level model: phase 0 idle, 1 feeding, 2 draining.
  int pend [NR];
  int fidx [NR];
  int bidx [NR];
  int ph, owner, mlast, cur_frame;
  int feed_cycles, drain_cycles, idle_run;
  int grants[$];
  int gaps[$];
  logic [OW-1:0] eng_sum;
  int eng_res_left, eng_k;
  int p_sv, p_er, p_rv, p_mr;
  bit er_toggle, er_phase;
  int mr_stall, mr_stall_cfg;

  function automatic logic [IW-1:0] mkdata(int r, int f, int b);
    return IW'((r << 24) | ((f & 255) << 16) | (b + 1));
  endfunction

  function automatic logic [OW-1:0] exp_res(int r, int f, int k);
    logic [OW-1:0] s;
    s = '0;
    for (int b = 0; b < INP; b++) s = s + OW'(mkdata(r, f, b));
    return s + OW'(k);
  endfunction

  function automatic int rr_next(logic [NR-1:0] v, int last);
    for (int k = 1; k <= NR; k++) begin
      if (v[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  function automatic bit all_done();
    for (int r = 0; r < NR; r++) if (pend[r] != 0) return 1'b0;
    return (ph == 0);
  endfunction

  function automatic bit coin(int p);
    return int'($urandom_range(99)) < p;
  endfunction

  task automatic model_reset();
    ph = 0; owner = 0; mlast = NR - 1;
    eng_sum = '0; eng_res_left = 0; eng_k = 0;
    idle_run = 0; feed_cycles = 0; drain_cycles = 0;
    for (int r = 0; r < NR; r++) begin pend[r] = 0; bidx[r] = 0; end
    grants.delete(); gaps.delete();
    p_sv = 100; p_er = 100; p_rv = 100; p_mr = 100;
    er_toggle = 1'b0; er_phase = 1'b1; mr_stall = 0; mr_stall_cfg = 0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    s_valid = '0; s_data = '0; e_ready = 1'b0; r_valid = 1'b0; r_data = '0; m_ready = '0;
    s2_valid = '0; s2_data = '0; e2_ready = 1'b0; r2_valid = 1'b0; r2_data = '0; m2_ready = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One cycle: drive at the falling edge, check 1 time unit later, advance the model.
  task automatic step();
    logic [NR-1:0] exp_v;
    for (int r = 0; r < NR; r++) begin
      s_valid[r] = (pend[r] > 0) && coin(p_sv);
      s_data[r*IW +: IW] = mkdata(r, fidx[r], bidx[r]);
    end
    if (er_toggle) begin
      e_ready = er_phase && (eng_res_left == 0);
      er_phase = !er_phase;
    end else begin
      e_ready = (eng_res_left == 0) && coin(p_er);
    end
    r_valid = (eng_res_left > 0) ? coin(p_rv) : 1'($urandom_range(1));
    r_data  = eng_sum + OW'(eng_k);
    for (int r = 0; r < NR; r++) m_ready[r] = coin(p_mr);
    if (ph == 2 && mr_stall > 0) begin m_ready = '0; mr_stall--; end
    #1;
    case (ph)
      0: begin
        idle_run++;
        checks++;
        if (busy !== 1'b0 || s_ready !== '0 || e_valid !== 1'b0 || m_valid !== '0 || r_ready !== 1'b0) begin
          errors++;
          $display("FAIL idle_outputs: busy=%b s_ready=%b e_valid=%b m_valid=%b r_ready=%b, required all 0",
                   busy, s_ready, e_valid, m_valid, r_ready);
        end
        if (|s_valid) begin
          owner = rr_next(s_valid, mlast);
          grants.push_back(owner);
          gaps.push_back(idle_run);
          idle_run = 0; feed_cycles = 0; drain_cycles = 0;
          cur_frame = fidx[owner];
          ph = 1;
        end
      end
      1: begin
        feed_cycles++;
        checks++;
        if (busy !== 1'b1 || grant_id !== IDW'(owner)) begin
          errors++;
          $display("FAIL feed_grant: busy=%b grant_id=%0d, required busy=1 grant_id=%0d", busy, grant_id, owner);
        end
        exp_v = '0;
        if (e_ready) exp_v[owner] = 1'b1;
        checks++;
        if (s_ready !== exp_v) begin
          errors++;
          $display("FAIL feed_s_ready: got %b, required %b", s_ready, exp_v);
        end
        checks++;
        if (e_valid !== s_valid[owner] || m_valid !== '0 || r_ready !== 1'b0) begin
          errors++;
          $display("FAIL feed_valids: e_valid=%b m_valid=%b r_ready=%b, required e_valid=%b m_valid=0 r_ready=0",
                   e_valid, m_valid, r_ready, s_valid[owner]);
        end
        if (s_valid[owner]) begin
          checks++;
          if (e_data !== mkdata(owner, fidx[owner], bidx[owner])) begin
            errors++;
            $display("FAIL feed_data: got %h, required %h", e_data, mkdata(owner, fidx[owner], bidx[owner]));
          end
        end
        if (s_valid[owner] && e_ready) begin
          eng_sum = eng_sum + OW'(e_data);
          bidx[owner]++;
          if (bidx[owner] == INP) begin
            bidx[owner] = 0; fidx[owner]++; pend[owner]--;
            eng_res_left = OD; eng_k = 0; mr_stall = mr_stall_cfg;
            ph = 2;
          end
        end
      end
      default: begin
        drain_cycles++;
        checks++;
        if (busy !== 1'b1 || e_valid !== 1'b0 || s_ready !== '0) begin
          errors++;
          $display("FAIL drain_idle_side: busy=%b e_valid=%b s_ready=%b, required 1/0/0", busy, e_valid, s_ready);
        end
        exp_v = '0;
        if (r_valid) exp_v[owner] = 1'b1;
        checks++;
        if (m_valid !== exp_v || r_ready !== m_ready[owner]) begin
          errors++;
          $display("FAIL drain_route: m_valid=%b r_ready=%b, required %b / %b", m_valid, r_ready, exp_v, m_ready[owner]);
        end
        if (r_valid) begin
          checks++;
          if (m_id !== IDW'(owner) || m_data !== exp_res(owner, cur_frame, eng_k)) begin
            errors++;
            $display("FAIL drain_result: id=%0d data=%h, required id=%0d data=%h",
                     m_id, m_data, owner, exp_res(owner, cur_frame, eng_k));
          end
        end
        if (r_valid && m_ready[owner]) begin
          eng_k++; eng_res_left--;
          if (eng_res_left == 0) begin
            ph = 0; mlast = owner; eng_sum = '0;
          end
        end
      end
    endcase
    @(negedge clk);
  endtask

  task automatic run_to_done(string name, int budget);
    int n;
    n = 0;
    while (!all_done() && n < budget) begin step(); n++; end
    checks++;
    if (!all_done()) begin
      errors++;
      $display("FAIL %s_timeout: frames still pending after %0d cycles, required completion", name, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_valid = '1; e_ready = 1'b1; r_valid = 1'b1; m_ready = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || grant_id !== '0 || m_id !== '0 || s_ready !== '0 || e_valid !== 1'b0 ||
        r_ready !== 1'b0 || m_valid !== '0 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b grant=%0d id=%0d s_ready=%b e_valid=%b r_ready=%b m_valid=%b busy2=%b, required all 0",
               busy, grant_id, m_id, s_ready, e_valid, r_ready, m_valid, busy2);
    end
    reset_dut();
  endtask

  task automatic test_single();
    reset_dut();
    pend[2] = 1;
    run_to_done("single", 60);
    step();
    checks++;
    if (grants.size() != 1 || grants[0] != 2 || feed_cycles != INP || drain_cycles != OD) begin
      errors++;
      $display("FAIL single_frame: grants=%0d first=%0d feed=%0d drain=%0d, required 1/2/%0d/%0d",
               grants.size(), (grants.size() > 0) ? grants[0] : -1, feed_cycles, drain_cycles, INP, OD);
    end
  endtask

  task automatic test_round_robin();
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};
    reset_dut();
    pend[0] = 2; pend[1] = 1; pend[2] = 1; pend[3] = 1;
    run_to_done("rr", 200);
    checks++;
    if (grants.size() != 5) begin
      errors++;
      $display("FAIL rr_count: got %0d frames, required 5", grants.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (grants[i] != exp_order[i] || gaps[i] != 1) begin
          errors++;
          $display("FAIL rr_order[%0d]: grant=%0d idle=%0d, required grant=%0d idle=1", i, grants[i], gaps[i], exp_order[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    reset_dut();
    pend[1] = 2;
    er_toggle = 1'b1; mr_stall_cfg = 5;
    run_to_done("bp", 200);
    checks++;
    if (grants.size() != 2 || grants[0] != 1 || grants[1] != 1) begin
      errors++;
      $display("FAIL bp_frames: got %0d frames, required 2 frames for requester 1", grants.size());
    end
  endtask

  task automatic test_isolation();
    reset_dut();
    pend[1] = 1; pend[3] = 1;
    run_to_done("iso", 100);
    checks++;
    if (grants.size() != 2 || grants[0] != 1 || grants[1] != 3) begin
      errors++;
      $display("FAIL iso_order: got %0d frames first=%0d, required order 1,3", grants.size(),
               (grants.size() > 0) ? grants[0] : -1);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    reset_dut();
    for (int r = 0; r < NR; r++) pend[r] = 1;
    n = 0;
    while (!(ph == 1 && owner == 2 && bidx[2] == 4) && n < 200) begin step(); n++; end
    checks++;
    if (!(ph == 1 && owner == 2 && bidx[2] == 4)) begin
      errors++;
      $display("FAIL midreset_reach: did not reach beat 4 of requester 2 within 200 cycles");
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || s_ready !== '0 || e_valid !== 1'b0 || m_valid !== '0 || r_ready !== 1'b0 ||
        m_id !== '0 || grant_id !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: busy=%b s_ready=%b e_valid=%b m_valid=%b r_ready=%b id=%0d grant=%0d, required all 0",
               busy, s_ready, e_valid, m_valid, r_ready, m_id, grant_id);
    end
    rst = 1'b0;
    model_reset();
    pend[0] = 1; pend[2] = 1; pend[3] = 1;
    run_to_done("midreset", 200);
    checks++;
    if (grants.size() != 3 || grants[0] != 0 || grants[1] != 2 || grants[2] != 3) begin
      errors++;
      $display("FAIL midreset_regrant: first=%0d count=%0d, required order 0,2,3",
               (grants.size() > 0) ? grants[0] : -1, grants.size());
    end
  endtask

  task automatic test_random();
    reset_dut();
    p_sv = 70; p_er = 60; p_rv = 65; p_mr = 55;
    for (int r = 0; r < NR; r++) pend[r] = int'($urandom_range(3));
    pend[int'($urandom_range(NR - 1))] += 1;
    run_to_done("random", 4000);
  endtask

  task automatic test_degenerate();
    logic [1:0] exp_sr [8];
    logic [1:0] exp_mv [8];
    logic       exp_busy [8];
    exp_sr   = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01};
    exp_mv   = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
    exp_busy = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    reset_dut();
    s2_valid = 2'b11; s2_data = {32'h0000_0B0B, 32'h0000_0A0A};
    e2_ready = 1'b1; r2_valid = 1'b1; r2_data = 32'h1234_5678; m2_ready = 2'b11;
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++;
      if (s2_ready !== exp_sr[c] || m2_valid !== exp_mv[c] || busy2 !== exp_busy[c] ||
          r2_ready !== (exp_mv[c] != 2'b00)) begin
        errors++;
        $display("FAIL degen_cycle%0d: s_ready=%b m_valid=%b busy=%b r_ready=%b, required %b/%b/%b/%b",
                 c, s2_ready, m2_valid, busy2, r2_ready, exp_sr[c], exp_mv[c], exp_busy[c], exp_mv[c] != 2'b00);
      end
      if (exp_sr[c] != 2'b00) begin
        checks++;
        if (e2_data !== (exp_sr[c][1] ? 32'h0000_0B0B : 32'h0000_0A0A)) begin
          errors++;
          $display("FAIL degen_data%0d: got %h", c, e2_data);
        end
      end
      if (exp_mv[c] != 2'b00) begin
        checks++;
        if (m2_id !== exp_mv[c][1] || m2_data !== 32'h1234_5678) begin
          errors++;
          $display("FAIL degen_result%0d: id=%0d data=%h, required id=%0d data=12345678", c, m2_id, m2_data, exp_mv[c][1]);
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    for (int r = 0; r < NR; r++) fidx[r] = 0;
    model_reset();
    rst = 1'b1;
    s_valid = '0; s_data = '0; e_ready = 1'b0; r_valid = 1'b0; r_data = '0; m_ready = '0;
    s2_valid = '0; s2_data = '0; e2_ready = 1'b0; r2_valid = 1'b0; r2_data = '0; m2_ready = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_isolation();
    test_reset_mid_frame();
    test_random();
    test_degenerate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
